// File: rtl/led_pkg.sv
// Shared types for the multi-channel LED pattern generator: channel modes
// and the configuration word carried from the config port into each channel.
package led_pkg;

    localparam int LED_MODE_W    = 2;
    // Period/duty are carried at this fixed width and zero-extended from CNT_W.
    localparam int LED_CNT_MAX_W = 32;

    typedef enum logic [LED_MODE_W-1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_e;

    typedef struct packed {
        led_mode_e                mode;
        logic [LED_CNT_MAX_W-1:0] period;
        logic [LED_CNT_MAX_W-1:0] duty;
    } led_cfg_t;

    localparam led_cfg_t LED_CFG_RESET = '{mode: LED_OFF, period: '0, duty: '0};

    // BLINK and PWM are the modes that run the cycle counter and produce wraps.
    function automatic logic mode_is_running(input led_mode_e mode);
        return (mode == LED_BLINK) || (mode == LED_PWM);
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: cycle counter, active/shadow configuration with a pending
// flag, and the registered led / wrap_pulse outputs.
module led_channel
    import led_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     tick,
    input  logic     cfg_wr,
    input  led_cfg_t cfg_in,
    output logic     led,
    output logic     wrap_pulse,
    output logic     pending
);

    led_cfg_t                 active_reg;
    led_cfg_t                 active_next;
    led_cfg_t                 shadow_reg;
    led_cfg_t                 shadow_next;
    logic                     pending_reg;
    logic                     pending_next;
    logic [CNT_W-1:0]         counter_reg;
    logic [CNT_W-1:0]         counter_next;
    logic                     led_reg;
    logic                     led_next;
    logic                     wrap_pulse_reg;
    logic [LED_CNT_MAX_W-1:0] counter_ext;
    logic                     running;
    logic                     at_terminal;
    logic                     wrap;

    assign counter_ext = LED_CNT_MAX_W'(counter_reg);
    assign running     = mode_is_running(active_reg.mode);
    assign at_terminal = (counter_ext == active_reg.period);
    assign wrap        = running & tick & at_terminal;

    always_comb begin
        active_next  = active_reg;
        shadow_next  = shadow_reg;
        pending_next = pending_reg;
        counter_next = counter_reg;
        led_next     = led_reg;

        case (active_reg.mode)
            LED_OFF:   led_next = 1'b0;
            LED_ON:    led_next = 1'b1;
            LED_BLINK: led_next = wrap ? ~led_reg : led_reg;
            LED_PWM:   led_next = (counter_ext < active_reg.duty);
            default:   led_next = 1'b0;
        endcase

        if (!running) begin
            counter_next = '0;
        end else if (tick) begin
            counter_next = at_terminal ? '0 : counter_reg + 1'b1;
        end

        // A queued config only takes over on a wrap, after the old mode's
        // wrap action above, so no partial cycle is ever emitted.
        if (wrap && pending_reg) begin
            active_next  = shadow_reg;
            counter_next = '0;
            pending_next = 1'b0;
        end

        // pending_reg is 0 whenever a write can be accepted, so a write that
        // coincides with a wrap lands in the shadow for the following wrap.
        if (cfg_wr) begin
            if (running) begin
                shadow_next  = cfg_in;
                pending_next = 1'b1;
            end else begin
                active_next  = cfg_in;
                counter_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_reg     <= LED_CFG_RESET;
            shadow_reg     <= LED_CFG_RESET;
            pending_reg    <= 1'b0;
            counter_reg    <= '0;
            led_reg        <= 1'b0;
            wrap_pulse_reg <= 1'b0;
        end else begin
            active_reg     <= active_next;
            shadow_reg     <= shadow_next;
            pending_reg    <= pending_next;
            counter_reg    <= counter_next;
            led_reg        <= led_next;
            wrap_pulse_reg <= wrap;
        end
    end

    assign led        = led_reg;
    assign wrap_pulse = wrap_pulse_reg;
    assign pending    = pending_reg;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler, config-port
// channel decode and per-channel ready mux around NUM_CH led_channel blocks.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int  NUM_CH   = 4,
    parameter int  CNT_W    = 16,
    parameter int  PRESCALE = 1,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [LED_MODE_W-1:0] cfg_mode,
    input  logic [CNT_W-1:0]      cfg_period,
    input  logic [CNT_W-1:0]      cfg_duty,
    output logic [NUM_CH-1:0]     led,
    output logic [NUM_CH-1:0]     wrap_pulse
);

    localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CH_SLOTS = 1 << CH_W;

    if (NUM_CH < 1) begin : g_bad_num_ch
        $fatal(1, "led_pattern_gen: NUM_CH must be >= 1");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $fatal(1, "led_pattern_gen: PRESCALE must be >= 1");
    end
    if ((CNT_W < 1) || (CNT_W > LED_CNT_MAX_W)) begin : g_bad_cnt_w
        $fatal(1, "led_pattern_gen: CNT_W out of range");
    end

    logic [PS_W-1:0]     presc_reg;
    logic [PS_W-1:0]     presc_next;
    logic                tick;
    logic [NUM_CH-1:0]   pending;
    logic [CH_SLOTS-1:0] pending_ext;
    logic [NUM_CH-1:0]   ch_wr;
    logic                cfg_fire;
    led_cfg_t            cfg_word;

    assign tick       = (presc_reg == PS_W'(PRESCALE - 1));
    assign presc_next = tick ? '0 : presc_reg + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end

    // Unused channel codes read as "not pending": such writes are taken and dropped.
    for (genvar gi = 0; gi < CH_SLOTS; gi++) begin : g_pend_ext
        if (gi < NUM_CH) begin : g_real
            assign pending_ext[gi] = pending[gi];
        end else begin : g_void
            assign pending_ext[gi] = 1'b0;
        end
    end

    assign cfg_ready = ~pending_ext[cfg_ch];
    assign cfg_fire  = cfg_valid & cfg_ready;

    assign cfg_word.mode   = led_mode_e'(cfg_mode);
    assign cfg_word.period = LED_CNT_MAX_W'(cfg_period);
    assign cfg_word.duty   = LED_CNT_MAX_W'(cfg_duty);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_wr[gi] = cfg_fire && (cfg_ch == CH_W'(gi));

        led_channel #(
            .CNT_W(CNT_W)
        ) u_channel (
            .clk        (clk),
            .reset_n    (reset_n),
            .tick       (tick),
            .cfg_wr     (ch_wr[gi]),
            .cfg_in     (cfg_word),
            .led        (led[gi]),
            .wrap_pulse (wrap_pulse[gi]),
            .pending    (pending[gi])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised scoreboard bench for led_pattern_gen: two instances (4ch/PRESCALE=1
// and 5ch/PRESCALE=4) checked against a tick-arithmetic reference model.
module tb_led_pattern_gen;

    localparam int N0 = 4, W0 = 16, P0 = 1;
    localparam int N1 = 5, W1 = 8,  P1 = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int in_v[2], in_ch[2], in_m[2], in_per[2], in_duty[2];

    logic          v0, v1, rdy0, rdy1;
    logic [1:0]    ch0, m0, m1;
    logic [2:0]    ch1;
    logic [W0-1:0] per0, duty0;
    logic [W1-1:0] per1, duty1;
    logic [N0-1:0] led0, wp0;
    logic [N1-1:0] led1, wp1;

    assign v0    = (in_v[0] != 0);
    assign ch0   = in_ch[0][1:0];
    assign m0    = in_m[0][1:0];
    assign per0  = in_per[0][W0-1:0];
    assign duty0 = in_duty[0][W0-1:0];
    assign v1    = (in_v[1] != 0);
    assign ch1   = in_ch[1][2:0];
    assign m1    = in_m[1][1:0];
    assign per1  = in_per[1][W1-1:0];
    assign duty1 = in_duty[1][W1-1:0];

    led_pattern_gen #(.NUM_CH(N0), .CNT_W(W0), .PRESCALE(P0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .cfg_valid(v0), .cfg_ready(rdy0), .cfg_ch(ch0),
        .cfg_mode(m0), .cfg_period(per0), .cfg_duty(duty0), .led(led0), .wrap_pulse(wp0));

    led_pattern_gen #(.NUM_CH(N1), .CNT_W(W1), .PRESCALE(P1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .cfg_valid(v1), .cfg_ready(rdy1), .cfg_ch(ch1),
        .cfg_mode(m1), .cfg_period(per1), .cfg_duty(duty1), .led(led1), .wrap_pulse(wp1));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel is described by when its current config became active
    // (t_act, in ticks) and the led level right after that; outputs follow
    // from elapsed ticks modulo the cycle length period+1.
    int NCH[2] = '{N0, N1};
    int PSC[2] = '{P0, P1};
    int a_mode[2][8], a_per[2][8], a_duty[2][8];
    int s_mode[2][8], s_per[2][8], s_duty[2][8];
    int pend[2][8], t_act[2][8], base[2][8];
    int cyc[2], tcnt[2];

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 0; tcnt[d] = 0;
            for (int c = 0; c < 8; c++) begin
                a_mode[d][c] = 0; a_per[d][c] = 0; a_duty[d][c] = 0;
                s_mode[d][c] = 0; s_per[d][c] = 0; s_duty[d][c] = 0;
                pend[d][c] = 0; t_act[d][c] = 0; base[d][c] = 0;
            end
        end
    endtask

    function automatic int m_ready(input int d, input int ch);
        if (ch >= NCH[d]) return 1;
        return (pend[d][ch] == 0) ? 1 : 0;
    endfunction

    task automatic m_edge(input int d, output bit acc, output int led_v, output int wrap_v);
        bit tick, running, w;
        int t_before, t_after, len, el_b, el_a, l;
        tick     = ((cyc[d] % PSC[d]) == PSC[d] - 1);
        t_before = tcnt[d];
        t_after  = t_before + (tick ? 1 : 0);
        acc      = (in_v[d] != 0) && (m_ready(d, in_ch[d]) != 0);
        led_v    = 0;
        wrap_v   = 0;
        for (int c = 0; c < NCH[d]; c++) begin
            len     = a_per[d][c] + 1;
            el_b    = t_before - t_act[d][c];
            el_a    = t_after - t_act[d][c];
            running = (a_mode[d][c] >= 2);
            w       = running && tick && (el_a > 0) && ((el_a % len) == 0);
            case (a_mode[d][c])
                0:       l = 0;
                1:       l = 1;
                2:       l = base[d][c] ^ ((el_a / len) % 2);
                default: l = ((el_b % len) < a_duty[d][c]) ? 1 : 0;
            endcase
            if (w && pend[d][c] != 0) begin
                a_mode[d][c] = s_mode[d][c]; a_per[d][c] = s_per[d][c]; a_duty[d][c] = s_duty[d][c];
                t_act[d][c] = t_after; base[d][c] = l; pend[d][c] = 0;
            end
            if (acc && in_ch[d] == c) begin
                if (running) begin
                    s_mode[d][c] = in_m[d]; s_per[d][c] = in_per[d]; s_duty[d][c] = in_duty[d];
                    pend[d][c] = 1;
                end else begin
                    a_mode[d][c] = in_m[d]; a_per[d][c] = in_per[d]; a_duty[d][c] = in_duty[d];
                    t_act[d][c] = t_after; base[d][c] = l;
                end
            end
            led_v  = led_v | (l << c);
            wrap_v = wrap_v | (int'(w) << c);
        end
        cyc[d]++;
        tcnt[d] = t_after;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0] led0;
        logic [7:0] wrap0;
        logic [7:0] led1;
        logic [7:0] wrap1;
    } exp_t;
    exp_t exp_q[$];

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("led0",  int'(led0), int'(e.led0));
                chk("wrap0", int'(wp0),  int'(e.wrap0));
                chk("led1",  int'(led1), int'(e.led1));
                chk("wrap1", int'(wp1),  int'(e.wrap1));
            end
        end
    end

    // One clock of both DUTs: check ready, predict, push expectation.
    task automatic step(output bit acc0, output bit acc1);
        exp_t e;
        int l, w;
        #1;
        chk("cfg_ready0", int'(rdy0), m_ready(0, in_ch[0]));
        chk("cfg_ready1", int'(rdy1), m_ready(1, in_ch[1]));
        m_edge(0, acc0, l, w);
        e.led0 = 8'(l); e.wrap0 = 8'(w);
        m_edge(1, acc1, l, w);
        e.led1 = 8'(l); e.wrap1 = 8'(w);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        bit a0, a1;
        for (int i = 0; i < n; i++) step(a0, a1);
    endtask

    task automatic cfg_write(input int d, input int ch, input int mode, input int per,
                             input int duty, input int budget, output int nsteps);
        bit a0, a1, acc;
        in_v[d] = 1; in_ch[d] = ch; in_m[d] = mode; in_per[d] = per; in_duty[d] = duty;
        acc = 0;
        nsteps = 0;
        while (!acc && nsteps < budget) begin
            step(a0, a1);
            acc = (d == 0) ? a0 : a1;
            nsteps++;
        end
        in_v[d] = 0;
        chk("write_accepted", int'(acc), 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_led0",  int'(led0), 0);
        chk("rst_wrap0", int'(wp0),  0);
        chk("rst_led1",  int'(led1), 0);
        chk("rst_wrap1", int'(wp1),  0);
        exp_q.delete();
        m_reset();
        for (int d = 0; d < 2; d++) begin
            in_v[d] = 0; in_ch[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("ready0_after_reset", int'(rdy0), 1);
        chk("ready1_after_reset", int'(rdy1), 1);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            in_v[d] = 0; in_ch[d] = 0; in_m[d] = 0; in_per[d] = 0; in_duty[d] = 0;
        end
        reset_n = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // BLINK ch0 period 3 on the fast instance
        cfg_write(0, 0, 2, 3, 0, 5, n);
        idle(20);

        // PWM ch1 period 9: duty 3, then 0, then 12 (queued behind wraps)
        cfg_write(0, 1, 3, 9, 3, 5, n);
        idle(30);
        cfg_write(0, 1, 3, 9, 0, 20, n);
        idle(30);
        cfg_write(0, 1, 3, 9, 12, 20, n);
        idle(30);

        // ch2 BLINK period 100; PWM written at count 10, second write stalls to the wrap
        cfg_write(0, 2, 2, 100, 0, 5, n);
        idle(10);
        cfg_write(0, 2, 3, 50, 20, 5, n);
        cfg_write(0, 2, 1, 0, 0, 200, n);
        chk("queued_stall_cycles", n - 1, 90);
        idle(10);

        // Independence: reconfigure ch3 while ch0 blinks
        idle(2);
        cfg_write(0, 3, 3, 5, 2, 5, n);
        idle(15);

        // Reset mid-BLINK with a config queued on ch1
        cfg_write(0, 1, 0, 0, 0, 20, n);
        do_reset();
        idle(10);

        // Slow instance: BLINK period 0, OFF->ON, invalid channels
        cfg_write(1, 0, 2, 0, 0, 5, n);
        idle(20);
        cfg_write(1, 1, 1, 0, 0, 5, n);
        idle(3);
        cfg_write(1, 2, 3, 4, 2, 5, n);
        idle(6);
        cfg_write(1, 5, 3, 3, 1, 5, n);
        cfg_write(1, 7, 1, 0, 0, 5, n);
        idle(20);

        // Randomised traffic on both instances
        for (int i = 0; i < 60; i++) begin
            cfg_write(0, $urandom_range(0, N0 - 1), $urandom_range(0, 3),
                      $urandom_range(0, 7), $urandom_range(0, 9), 100, n);
            idle($urandom_range(0, 6));
        end
        for (int i = 0; i < 40; i++) begin
            cfg_write(1, $urandom_range(0, 7), $urandom_range(0, 3),
                      $urandom_range(0, 5), $urandom_range(0, 7), 150, n);
            idle($urandom_range(0, 10));
        end
        idle(40);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
